// File: rtl/soc_system_pio_in_capture.sv
// Avalon-MM input PIO: synchronised input bus, per-bit edge capture (W1C),
// maskable level/edge interrupt, read latency 1.
module soc_system_pio_in_capture #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  // Synchroniser kept as one packed vector; stage 0 in the low slice.
  logic [SYNC_STAGES*DATA_WIDTH-1:0] sync_chain;
  logic [DATA_WIDTH-1:0]             sync;
  logic [DATA_WIDTH-1:0]             prev;
  logic [DATA_WIDTH-1:0]             irqmask;
  logic [DATA_WIDTH-1:0]             edgecapture;
  logic [DATA_WIDTH-1:0]             edge_det;
  logic [DATA_WIDTH-1:0]             wdata;
  logic [DATA_WIDTH-1:0]             clr;
  logic                              wr_en;
  logic [31:0]                       rd_mux;

  assign sync  = sync_chain[SYNC_STAGES*DATA_WIDTH-1 -: DATA_WIDTH];
  assign wdata = writedata[DATA_WIDTH-1:0];
  assign wr_en = chipselect & ~write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain <= '0;
      prev       <= '0;
    end else begin
      sync_chain <= {sync_chain[(SYNC_STAGES-1)*DATA_WIDTH-1:0], in_port};
      prev       <= sync;
    end
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = sync & ~prev;
      1:       edge_det = ~sync & prev;
      default: edge_det = sync ^ prev;
    endcase
  end

  always_comb begin
    clr = '0;
    if (wr_en && address == 2'd3) clr = wdata;
  end

  // A new edge overrides a simultaneous write-1-to-clear on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_en && address == 2'd2) irqmask <= wdata;
      edgecapture <= (edgecapture & ~clr) | edge_det;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[DATA_WIDTH-1:0] = sync;
      2'd2:    rd_mux[DATA_WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[DATA_WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      if (IRQ_MODE == 0) irq <= |(sync & irqmask);
      else               irq <= |(edgecapture & irqmask);
    end
  end

endmodule

// File: tb/tb_soc_system_pio_in_capture.sv
// Bench for soc_system_pio_in_capture: instance A (8-bit, rising, edge irq)
// and instance B (4-bit, any edge, level irq, 3 sync stages) on a shared bus.
module tb_soc_system_pio_in_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs_a, cs_b;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd_a, rd_b;
  logic [7:0]  in_a;
  logic [3:0]  in_b;
  logic        irq_a, irq_b;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  soc_system_pio_in_capture #(
    .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .irq(irq_a)
  );

  soc_system_pio_in_capture #(
    .DATA_WIDTH(4), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_MODE(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .irq(irq_b)
  );

  typedef struct {
    string       name;
    logic [31:0] ea;
    logic [31:0] eb;
    bit          ca;
    bit          cb;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0]  in_val;
    logic [31:0] wmask;
    logic [31:0] exp_data;
    logic [31:0] exp_mask;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit to_b, input logic [1:0] a, input logic [31:0] d);
    cs_a = !to_b; cs_b = to_b; write_n = 1'b0; address = a; writedata = d;
    cyc();
    cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input bit ca, input logic [31:0] ea,
                    input bit cb, input logic [31:0] eb, input string n);
    exp_t e;
    address = a;
    sbq.push_back('{name: n, ea: ea, eb: eb, ca: ca, cb: cb});
    cyc();
    e = sbq.pop_front();
    if (e.ca) chk({e.name, "_a"}, rd_a, e.ea);
    if (e.cb) chk({e.name, "_b"}, rd_b, e.eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    vecs[0] = '{in_val: 8'hA5, wmask: 32'hFFFF_FF3C, exp_data: 32'h0000_00A5, exp_mask: 32'h0000_003C};
    vecs[1] = '{in_val: 8'h5A, wmask: 32'h0000_0100, exp_data: 32'h0000_005A, exp_mask: 32'h0000_0000};
    vecs[2] = '{in_val: 8'h00, wmask: 32'h0000_00FF, exp_data: 32'h0000_0000, exp_mask: 32'h0000_00FF};
    vecs[3] = '{in_val: 8'hC3, wmask: 32'h8000_0081, exp_data: 32'h0000_00C3, exp_mask: 32'h0000_0081};

    reset_n = 1'b0; address = 2'd0; cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1;
    writedata = '0; in_a = 8'hFF; in_b = 4'hF;

    // Reset values and first valid read after release
    idle(3);
    chk("rst_rd_a", rd_a, 32'h0);
    chk("rst_rd_b", rd_b, 32'h0);
    chk("rst_irq_a", {31'h0, irq_a}, 32'h0);
    chk("rst_irq_b", {31'h0, irq_b}, 32'h0);
    reset_n = 1'b1;
    rd(2'd0, 1, 32'h0,  1, 32'h0, "rel_e1");
    rd(2'd0, 1, 32'h0,  1, 32'h0, "rel_e2");
    rd(2'd0, 1, 32'hFF, 1, 32'h0, "rel_e3");
    rd(2'd0, 1, 32'hFF, 1, 32'hF, "rel_e4");
    chk("rel_irq_a", {31'h0, irq_a}, 32'h0);
    rd(2'd3, 1, 32'hFF, 0, 32'h0, "rel_cap");
    rd(2'd1, 1, 32'h0,  1, 32'h0, "reserved");

    // Table: data path and irqmask truncation on instance A
    for (int i = 0; i < 4; i++) begin
      in_a = vecs[i].in_val;
      wr(1'b0, 2'd2, vecs[i].wmask);
      idle(2);
      rd(2'd0, 1, vecs[i].exp_data, 0, 32'h0, "tbl_data");
      rd(2'd2, 1, vecs[i].exp_mask, 0, 32'h0, "tbl_mask");
    end
    wr(1'b0, 2'd2, 32'h0);
    in_a = 8'h00;
    idle(3);
    wr(1'b0, 3'd3, 32'hFF);
    rd(2'd3, 1, 32'h0, 0, 32'h0, "clr_all");
    chk("clr_irq_a", {31'h0, irq_a}, 32'h0);

    // Data latency: value sampled at edge k appears on readdata after k+2
    in_a = 8'hA5;
    rd(2'd0, 1, 32'h0,  0, 32'h0, "lat_k");
    rd(2'd0, 1, 32'h0,  0, 32'h0, "lat_k1");
    rd(2'd0, 1, 32'hA5, 0, 32'h0, "lat_k2");

    // Rising capture, edge irq, W1C
    in_a = 8'h00;
    idle(3);
    wr(1'b0, 2'd3, 32'hFF);
    wr(1'b0, 2'd2, 32'h01);
    cyc();
    in_a = 8'h01;
    rd(2'd3, 1, 32'h0, 0, 32'h0, "cap_k");
    rd(2'd3, 1, 32'h0, 0, 32'h0, "cap_k1");
    rd(2'd3, 1, 32'h0, 0, 32'h0, "cap_k2");
    chk("cap_irq_k2", {31'h0, irq_a}, 32'h0);
    in_a = 8'h00;
    rd(2'd3, 1, 32'h1, 0, 32'h0, "cap_k3");
    chk("cap_irq_k3", {31'h0, irq_a}, 32'h1);
    idle(3);
    rd(2'd3, 1, 32'h1, 0, 32'h0, "cap_no_fall");
    wr(1'b0, 2'd3, 32'h1);
    chk("w1c_irq_w", {31'h0, irq_a}, 32'h1);
    rd(2'd3, 1, 32'h0, 0, 32'h0, "w1c_rd");
    chk("w1c_irq_w1", {31'h0, irq_a}, 32'h0);

    // Set/clear collision on bit 3: set wins
    in_a = 8'h08;
    idle(2);
    wr(1'b0, 2'd3, 32'h08);
    rd(2'd3, 1, 32'h08, 0, 32'h0, "collide");
    chk("collide_irq_masked", {31'h0, irq_a}, 32'h0);
    in_a = 8'h00;
    idle(3);
    wr(1'b0, 2'd3, 32'h08);
    rd(2'd3, 1, 32'h0, 0, 32'h0, "collide_clr");

    // Level-mode irq and masking on instance B
    in_b = 4'h2;
    idle(4);
    chk("lvl_irq_unmasked0", {31'h0, irq_b}, 32'h0);
    cyc();
    chk("lvl_irq_unmasked1", {31'h0, irq_b}, 32'h0);
    wr(1'b1, 2'd2, 32'h2);
    chk("lvl_irq_w", {31'h0, irq_b}, 32'h0);
    cyc();
    chk("lvl_irq_w1", {31'h0, irq_b}, 32'h1);
    wr(1'b1, 2'd2, 32'h0);
    chk("lvl_irq_off_w", {31'h0, irq_b}, 32'h1);
    cyc();
    chk("lvl_irq_off_w1", {31'h0, irq_b}, 32'h0);

    // Any-edge capture and width truncation on instance B
    in_b = 4'h0;
    idle(4);
    wr(1'b1, 2'd3, 32'hF);
    rd(2'd3, 0, 32'h0, 1, 32'h0, "any_clr");
    in_b = 4'h4;
    idle(4);
    rd(2'd3, 0, 32'h0, 1, 32'h4, "any_rise");
    wr(1'b1, 2'd3, 32'h4);
    rd(2'd3, 0, 32'h0, 1, 32'h0, "any_w1c1");
    in_b = 4'h0;
    idle(4);
    rd(2'd3, 0, 32'h0, 1, 32'h4, "any_fall");
    wr(1'b1, 2'd3, 32'h4);
    rd(2'd3, 0, 32'h0, 1, 32'h0, "any_w1c2");
    wr(1'b1, 2'd2, 32'hFFFF_FFF0);
    rd(2'd2, 0, 32'h0, 1, 32'h0, "width_mask_hi");
    wr(1'b1, 2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 0, 32'h0, 1, 32'hF, "width_mask_all");
    wr(1'b1, 2'd2, 32'h0);

    // Asynchronous reset mid-operation
    wr(1'b0, 2'd2, 32'hFF);
    in_a = 8'h55;
    idle(4);
    rd(2'd0, 1, 32'h55, 0, 32'h0, "pre_rst");
    chk("pre_rst_irq", {31'h0, irq_a}, 32'h1);
    reset_n = 1'b0;
    #2;
    chk("async_rst_rd_a", rd_a, 32'h0);
    chk("async_rst_irq_a", {31'h0, irq_a}, 32'h0);
    chk("async_rst_rd_b", rd_b, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
